bus_arbiter16: RTL and testbench
================================

Name: bus_arbiter16

Overview:
Two-requester round-robin arbiter that shares one 16-bit bus, driven by the existing MUX16 gate, between requester A and requester B. It sequences bus ownership with a req/grant/last handshake toward the requesters and a valid/ready handshake toward the single downstream consumer. A hold limit bounds each tenure so neither requester starves. It sits between the CPU-side masters (for example, instruction fetch and data port) and the shared memory/IO bus of the LittleComputer.

Parameters:
MAX_HOLD, 4, maximum beats one requester may transfer per tenure before it must yield (1..15)
CNT_W, 4, width of the beat counter; must hold MAX_HOLD

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
req_a  input  1  requester A wants the bus; held high while it has beats to send
data_a  input  16  requester A bus data
last_a  input  1  current A beat is the final beat of its burst
req_b  input  1  requester B wants the bus
data_b  input  16  requester B bus data
last_b  input  1  current B beat is the final beat of its burst
ready  input  1  downstream accepts a beat this cycle
gnt_a  output  1  A owns the bus (registered)
gnt_b  output  1  B owns the bus (registered)
sel  output  1  MUX16 select: 0 routes A, 1 routes B (registered)
valid  output  1  beat present on data_out
data_out  output  16  muxed bus data

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-high.
- Reset values: state IDLE, gnt_a=0, gnt_b=0, sel=0, beat_cnt=0, prio=A (A wins a tie). While reset is high, valid=0 and data_out=data_a.
- States: IDLE, OWN_A, OWN_B. gnt_a is 1 only in OWN_A and gnt_b only in OWN_B; they are never both 1.
- Datapath: data_out = MUX16(sel, data_a, data_b). valid = (gnt_a & req_a) | (gnt_b & req_b). A beat is valid & ready.
- IDLE:
  - Only one requester asserts its req: grant it at the next edge.
  - Both assert: grant the one named by prio.
  - Neither asserts: stay in IDLE.
  - sel keeps its last value in IDLE.
  - Latency: the first possible beat comes 1 cycle after req rises from IDLE.
- OWN_x: each beat increments beat_cnt. A release is triggered by any of the following:
  - (a) a beat with last_x=1;
  - (b) a beat that brings beat_cnt to MAX_HOLD;
  - (c) req_x=0 while granted. This is not a beat; the release happens at the next edge.
- On release:
  - beat_cnt clears and prio points to the other requester.
  - The next state is OWN_other if req_other=1. This is a direct handoff with no IDLE bubble, and sel flips in the same edge.
  - Otherwise the next state is OWN_x again (new tenure, counter cleared) if req_x=1 and the release was (a) or (b).
  - Otherwise the next state is IDLE.
- Stalls: with ready=0, state, beat_cnt and grant hold. Requesters must hold data/last stable while valid & !ready.
- Simultaneous events: last_x and the hold limit on the same beat count as one release. A req rising on the other side in the release cycle is honoured by the handoff rule above.
- Reset mid-burst: the grant drops immediately (async), and any in-flight beat is abandoned. Requesters re-request after reset deasserts.
- Width rules: beat_cnt is CNT_W bits and never exceeds MAX_HOLD, so there is no wrap.

Decomposition:
- Shared package/header: state encodings IDLE=2'b00, OWN_A=2'b01, OWN_B=2'b10, plus SEL_A=1'b0 and SEL_B=1'b1.
- One sub-module: the existing MUX16 from ElementaryLogicGates.v, instantiated for the data path. The FSM, counter and prio register stay in bus_arbiter16.

Test Plan:
- Single requester, MAX_HOLD=4, ready=1. req_a=1 with data_a=16'h00A1..00A3 and last_a on the 3rd beat → gnt_a at cycle 1, three beats 00A1/00A2/00A3 on data_out, then IDLE with gnt_a=0.
- Tie after reset: req_a=req_b=1 in the same cycle → gnt_a first (prio=A). After A's last beat, gnt_b and sel=1 at the next edge with no idle cycle.
- Hold limit: req_a held with last_a=0 and req_b=1 → exactly 4 A beats, then handoff to B. With req_b=0 instead → A re-granted with beat_cnt=0.
- Backpressure: during OWN_B, ready=0 for 3 cycles → valid=1, data_out stable at data_b=16'hBEEF, beat_cnt unchanged, gnt_b held.
- Requester withdraw: gnt_a=1, then req_a drops with no beat → valid=0 that cycle and IDLE next edge (or OWN_B if req_b=1).
- Async reset mid-burst: assert reset between clock edges while gnt_b=1 → gnt_b=0, valid=0, sel=0 immediately. After release, a tie grants A.

Source files
------------

// File: rtl/bus_arbiter16_pkg.sv
// Shared encodings for the two-requester bus arbiter: FSM states and MUX16 select values.
package bus_arbiter16_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    OWN_A = 2'b01,
    OWN_B = 2'b10
  } state_t;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  // Ownership state that corresponds to a select/priority side.
  function automatic state_t grant_state(input logic side);
    return (side == SEL_B) ? OWN_B : OWN_A;
  endfunction

endpackage

// File: rtl/bus_arbiter16_mux16.sv
// 16-bit two-way bus multiplexer: sel=0 routes a, sel=1 routes b. Purely combinational.
module bus_arbiter16_mux16 (
  input  logic        sel,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] out
);

  assign out = sel ? b : a;

endmodule

// File: rtl/bus_arbiter16.sv
// Round-robin arbiter for two requesters sharing one 16-bit bus; grant/sel registered, first beat 1 cycle after req.
// Backpressure: ready=0 freezes state, beat count and grant while valid holds.
module bus_arbiter16
  import bus_arbiter16_pkg::*;
#(
  parameter int MAX_HOLD = 4,
  parameter int CNT_W    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_a,
  input  logic [15:0] data_a,
  input  logic        last_a,
  input  logic        req_b,
  input  logic [15:0] data_b,
  input  logic        last_b,
  input  logic        ready,
  output logic        gnt_a,
  output logic        gnt_b,
  output logic        sel,
  output logic        valid,
  output logic [15:0] data_out
);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] beat_cnt, cnt_nxt;
  logic             prio, prio_nxt;
  logic             own_side, own_req, own_last, oth_req;
  logic             beat, rel_beat, rel_wd;

  assign valid    = (gnt_a & req_a) | (gnt_b & req_b);
  assign beat     = valid & ready;

  assign own_side = (state == OWN_B) ? SEL_B : SEL_A;
  assign own_req  = own_side ? req_b  : req_a;
  assign own_last = own_side ? last_b : last_a;
  assign oth_req  = own_side ? req_a  : req_b;

  // Last beat and hold-limit beat collapse into a single release.
  assign rel_beat = beat & (own_last | (beat_cnt == CNT_W'(MAX_HOLD - 1)));
  assign rel_wd   = (state != IDLE) & ~own_req;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = beat_cnt;
    prio_nxt  = prio;
    if (state == IDLE) begin
      if (req_a & req_b)
        state_nxt = grant_state(prio);
      else if (req_a)
        state_nxt = OWN_A;
      else if (req_b)
        state_nxt = OWN_B;
    end else if (rel_beat | rel_wd) begin
      cnt_nxt  = '0;
      prio_nxt = ~own_side;
      if (oth_req)
        state_nxt = grant_state(~own_side);
      else if (rel_beat & own_req)
        state_nxt = state;
      else
        state_nxt = IDLE;
    end else if (beat) begin
      cnt_nxt = beat_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      gnt_a    <= 1'b0;
      gnt_b    <= 1'b0;
      sel      <= SEL_A;
      beat_cnt <= '0;
      prio     <= SEL_A;
    end else begin
      state    <= state_nxt;
      gnt_a    <= (state_nxt == OWN_A);
      gnt_b    <= (state_nxt == OWN_B);
      if (state_nxt != IDLE)
        sel <= (state_nxt == OWN_B) ? SEL_B : SEL_A;
      beat_cnt <= cnt_nxt;
      prio     <= prio_nxt;
    end
  end

  bus_arbiter16_mux16 u_mux (
    .sel (sel),
    .a   (data_a),
    .b   (data_b),
    .out (data_out)
  );

endmodule

// File: tb/tb_bus_arbiter16.sv
// Bench for bus_arbiter16: directed cycle table, async-reset sequence, then random traffic vs a tenure model.
module tb_bus_arbiter16;

  localparam int MAX_HOLD = 4;
  localparam int NVEC     = 32;
  localparam int NRAND    = 600;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_a = 1'b0, last_a = 1'b0, req_b = 1'b0, last_b = 1'b0, ready = 1'b1;
  logic [15:0] data_a = '0, data_b = '0;
  logic        gnt_a, gnt_b, sel, valid;
  logic [15:0] data_out;
  logic [19:0] dut_o;

  bus_arbiter16 #(.MAX_HOLD(MAX_HOLD), .CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .req_a(req_a), .data_a(data_a), .last_a(last_a),
    .req_b(req_b), .data_b(data_b), .last_b(last_b),
    .ready(ready),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .sel(sel), .valid(valid), .data_out(data_out)
  );

  always #5 clk = ~clk;
  assign dut_o = {gnt_a, gnt_b, sel, valid, data_out};

  typedef struct {
    logic rst, ra, la, rb, lb, rdy;
    logic [15:0] da, db;
    logic [3:0]  e;      // {gnt_a, gnt_b, sel, valid}
    logic [15:0] edout;
  } vec_t;

  vec_t tbl [NVEC];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model state: who owns the bus, beats in this tenure, tie winner, last select.
  int   own;
  int   beats;
  bit   prio_b, msel, stalled;
  bit   mr, ml, orq, rel, by_beat;
  logic [19:0] exp_o;

  function automatic vec_t mk(input logic [5:0] c, input logic [15:0] da, input logic [15:0] db,
                              input logic [3:0] e, input logic [15:0] ed);
    vec_t v;
    {v.rst, v.ra, v.la, v.rb, v.lb, v.rdy} = c;
    v.da = da; v.db = db; v.e = e; v.edout = ed;
    return v;
  endfunction

  task automatic check(input string name, input logic [19:0] act, input logic [19:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: gnt_a/gnt_b/sel/valid=%b data_out=%h, expected %b %h",
               name, act[19:16], act[15:0], exp[19:16], exp[15:0]);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // ctl = {rst, req_a, last_a, req_b, last_b, ready}; e = {gnt_a, gnt_b, sel, valid}
    tbl[0]  = mk(6'b100001, 16'h00A1, 16'h0000, 4'b0000, 16'h00A1);
    tbl[1]  = mk(6'b010001, 16'h00A1, 16'h0000, 4'b0000, 16'h00A1);
    tbl[2]  = mk(6'b010001, 16'h00A1, 16'h0000, 4'b1001, 16'h00A1);
    tbl[3]  = mk(6'b010001, 16'h00A2, 16'h0000, 4'b1001, 16'h00A2);
    tbl[4]  = mk(6'b011001, 16'h00A3, 16'h0000, 4'b1001, 16'h00A3);
    tbl[5]  = mk(6'b000001, 16'h0000, 16'h0000, 4'b1000, 16'h0000);
    tbl[6]  = mk(6'b000001, 16'h0000, 16'h0000, 4'b0000, 16'h0000);
    tbl[7]  = mk(6'b100001, 16'h0011, 16'h0022, 4'b0000, 16'h0011);
    tbl[8]  = mk(6'b010101, 16'h0011, 16'h0022, 4'b0000, 16'h0011);
    tbl[9]  = mk(6'b011101, 16'h0011, 16'h0022, 4'b1001, 16'h0011);
    tbl[10] = mk(6'b000101, 16'h0011, 16'h0022, 4'b0111, 16'h0022);
    for (int i = 11; i <= 13; i++) tbl[i] = mk(6'b010101, 16'h0011, 16'h0022, 4'b0111, 16'h0022);
    for (int i = 14; i <= 20; i++) tbl[i] = mk(6'b010001, 16'h0033, 16'h0022, 4'b1001, 16'h0033);
    tbl[21] = mk(6'b010101, 16'h0033, 16'h0022, 4'b1001, 16'h0033);
    for (int i = 22; i <= 24; i++) tbl[i] = mk(6'b000100, 16'h0033, 16'hBEEF, 4'b0111, 16'hBEEF);
    for (int i = 25; i <= 27; i++) tbl[i] = mk(6'b000101, 16'h0033, 16'hBEEF, 4'b0111, 16'hBEEF);
    tbl[28] = mk(6'b010101, 16'h0033, 16'hBEEF, 4'b0111, 16'hBEEF);
    tbl[29] = mk(6'b010001, 16'h0044, 16'hBEEF, 4'b1001, 16'h0044);
    tbl[30] = mk(6'b000101, 16'h0044, 16'h5555, 4'b1000, 16'h0044);
    tbl[31] = mk(6'b000101, 16'h0044, 16'h5555, 4'b0111, 16'h5555);

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      reset = tbl[i].rst;
      {req_a, last_a, req_b, last_b, ready} = {tbl[i].ra, tbl[i].la, tbl[i].rb, tbl[i].lb, tbl[i].rdy};
      data_a = tbl[i].da;
      data_b = tbl[i].db;
      #1;
      check($sformatf("vec%0d", i), dut_o, {tbl[i].e, tbl[i].edout});
    end

    // Async reset between edges while B owns the bus.
    @(posedge clk);
    #3 reset = 1'b1;
    #1 check("async_reset", dut_o, {4'b0000, 16'h0044});
    @(negedge clk);
    reset = 1'b0;
    req_a = 1'b1; req_b = 1'b1; last_a = 1'b0; last_b = 1'b0; ready = 1'b1;
    #1 check("post_reset_idle", dut_o, {4'b0000, 16'h0044});
    @(posedge clk);
    #1 check("tie_after_reset", dut_o, {4'b1001, 16'h0044});

    // Random traffic against the tenure model.
    @(negedge clk);
    reset = 1'b1;
    req_a = 1'b0; req_b = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    own = 0; beats = 0; prio_b = 1'b0; msel = 1'b0; stalled = 1'b0;
    for (int n = 0; n < NRAND; n++) begin
      if (n != 0) @(negedge clk);
      ready = ($urandom_range(0, 3) != 0);
      if (!stalled) begin
        req_a  = ($urandom_range(0, 3) != 0);
        req_b  = ($urandom_range(0, 3) != 0);
        last_a = ($urandom_range(0, 3) == 0);
        last_b = ($urandom_range(0, 3) == 0);
        data_a = 16'($urandom);
        data_b = 16'($urandom);
      end
      #1;
      exp_o[19]   = (own == 1);
      exp_o[18]   = (own == 2);
      exp_o[17]   = msel;
      exp_o[16]   = (own == 1 && req_a) || (own == 2 && req_b);
      exp_o[15:0] = msel ? data_b : data_a;
      check($sformatf("rand%0d", n), dut_o, exp_o);
      stalled = exp_o[16] && !ready;

      @(posedge clk);
      if (own == 0) begin
        if (req_a && (!req_b || !prio_b)) own = 1;
        else if (req_b) own = 2;
      end else begin
        mr  = (own == 1) ? req_a  : req_b;
        ml  = (own == 1) ? last_a : last_b;
        orq = (own == 1) ? req_b  : req_a;
        rel = 1'b0; by_beat = 1'b0;
        if (!mr) rel = 1'b1;
        else if (ready) begin
          beats++;
          if (ml || beats == MAX_HOLD) begin rel = 1'b1; by_beat = 1'b1; end
        end
        if (rel) begin
          beats  = 0;
          prio_b = (own == 1);
          if (orq) own = 3 - own;
          else if (!by_beat) own = 0;
        end
      end
      if (own != 0) msel = (own == 2);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
